// File: rtl/trace_pkg.sv
// Shared constants and types for the trace capture unit.
// Sync frame is FF FF FF 7F sent low nibble first.
package trace_pkg;

    localparam logic [3:0] SYNC_RUN_NIBBLE = 4'hF;
    localparam logic [3:0] SYNC_END_NIBBLE = 4'h7;
    localparam int unsigned SYNC_RUN_LEN = 7;
    localparam logic [2:0] RUN_MAX = 3'(SYNC_RUN_LEN);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Saturating count of consecutive 0xF nibbles.
    function automatic logic [2:0] next_run(
        input logic [2:0] run,
        input logic [3:0] nib
    );
        if (nib != SYNC_RUN_NIBBLE) begin
            return 3'd0;
        end
        return (run == RUN_MAX) ? run : run + 3'd1;
    endfunction

endpackage

// File: rtl/trace_byte_fifo.sv
// First-word-fall-through byte FIFO for assembled trace bytes.
// A pop frees a slot in the same cycle, so push on full+pop is accepted.
module trace_byte_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trace_capture.sv
// Nibble-stream trace capture: finds FF FF FF 7F sync, assembles bytes
// and queues them in a FWFT FIFO for the consumer.
module trace_capture
    import trace_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       I_arm,
    input  logic [3:0] TRACEDATA,
    input  logic       I_clear_overflow,
    output logic [7:0] O_data,
    output logic       O_valid,
    input  logic       I_ready,
    output logic       O_locked,
    output logic       O_overflow,
    output logic [7:0] O_resync_count
);

    state_t     state;
    state_t     state_n;
    logic       phase;
    logic       phase_n;
    logic [3:0] low_nib;
    logic [3:0] low_nib_n;
    logic [2:0] run;
    logic [2:0] run_n;
    logic       sync;
    logic       push;
    logic       resync_inc;
    logic       pop;
    logic       full;
    logic       empty;
    logic       drop;
    logic [7:0] push_data;

    assign sync = (TRACEDATA == SYNC_END_NIBBLE) && (run == RUN_MAX);
    assign push_data = {TRACEDATA, low_nib};

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        low_nib_n  = low_nib;
        run_n      = run;
        push       = 1'b0;
        resync_inc = 1'b0;
        if (!I_arm) begin
            state_n = HUNT;
            phase_n = 1'b0;
            run_n   = 3'd0;
        end else begin
            run_n = next_run(run, TRACEDATA);
            unique case (state)
                HUNT: begin
                    if (sync) begin
                        state_n = LOCKED;
                        phase_n = 1'b0;
                    end
                end
                LOCKED: begin
                    if (phase) begin
                        push    = 1'b1;
                        phase_n = 1'b0;
                    end else if (sync) begin
                        // Sync landed on a low-nibble slot: realign, drop it.
                        resync_inc = 1'b1;
                    end else begin
                        low_nib_n = TRACEDATA;
                        phase_n   = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= HUNT;
            phase   <= 1'b0;
            low_nib <= 4'h0;
            run     <= 3'd0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            low_nib <= low_nib_n;
            run     <= run_n;
        end
    end

    assign pop  = !empty && I_ready;
    assign drop = push && full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            O_overflow     <= 1'b0;
            O_resync_count <= 8'h00;
        end else begin
            if (drop) begin
                O_overflow <= 1'b1;
            end else if (I_clear_overflow) begin
                O_overflow <= 1'b0;
            end
            if (resync_inc && (O_resync_count != 8'hFF)) begin
                O_resync_count <= O_resync_count + 8'h01;
            end
        end
    end

    trace_byte_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (O_data),
        .full     (full),
        .empty    (empty)
    );

    assign O_valid  = !empty;
    assign O_locked = (state == LOCKED);

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: vector table plus corner sequences.
// Expected values are hand-derived from the nibble streams.
module tb_trace_capture;

    logic       clk;
    logic       reset_n;
    logic       I_arm;
    logic [3:0] TRACEDATA;
    logic       I_clear_overflow;
    logic [7:0] O_data;
    logic       O_valid;
    logic       I_ready;
    logic       O_locked;
    logic       O_overflow;
    logic [7:0] O_resync_count;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic       arm;
        logic [3:0] nib;
        logic       exp_lock;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [7:0] exp_rs;
    } vec_t;

    vec_t tbl[$];

    trace_capture #(.FIFO_DEPTH(16)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .I_arm           (I_arm),
        .TRACEDATA       (TRACEDATA),
        .I_clear_overflow(I_clear_overflow),
        .O_data          (O_data),
        .O_valid         (O_valid),
        .I_ready         (I_ready),
        .O_locked        (O_locked),
        .O_overflow      (O_overflow),
        .O_resync_count  (O_resync_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic arm, input logic [3:0] nib,
                       input logic lk, input logic vl,
                       input logic [7:0] d, input logic [7:0] rs);
        vec_t v;
        v.arm = arm; v.nib = nib; v.exp_lock = lk;
        v.exp_valid = vl; v.exp_data = d; v.exp_rs = rs;
        tbl.push_back(v);
    endtask

    task automatic step(input logic arm, input logic [3:0] nib);
        I_arm = arm;
        TRACEDATA = nib;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic lock_seq();
        for (int i = 0; i < 7; i++) step(1'b1, 4'hF);
        step(1'b1, 4'h7);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        I_arm = 1'b0;
        TRACEDATA = 4'h0;
        I_clear_overflow = 1'b0;
        I_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", O_locked, 0);
        chk("rst_valid", O_valid, 0);
        chk("rst_data", O_data, 0);
        chk("rst_ovf", O_overflow, 0);
        chk("rst_resync", O_resync_count, 0);
        reset_n = 1'b1;

        // lock, data, unaligned-run, misaligned sync, hunt-no-lock
        for (int i = 0; i < 7; i++) add(1, 4'hF, 0, 0, 8'h00, 0);
        add(1, 4'h7, 1, 0, 8'h00, 0);
        add(1, 4'h4, 1, 0, 8'h00, 0);
        add(1, 4'h3, 1, 1, 8'h34, 0);
        add(1, 4'h2, 1, 0, 8'h00, 0);
        add(1, 4'h1, 1, 1, 8'h12, 0);
        for (int i = 0; i < 3; i++) begin
            add(1, 4'hF, 1, 0, 8'h00, 0);
            add(1, 4'hF, 1, 1, 8'hFF, 0);
        end
        add(1, 4'h7, 1, 0, 8'h00, 0);
        add(1, 4'h1, 1, 1, 8'h17, 0);
        add(1, 4'hC, 1, 0, 8'h00, 0);
        add(1, 4'hF, 1, 1, 8'hFC, 0);
        for (int i = 0; i < 3; i++) begin
            add(1, 4'hF, 1, 0, 8'h00, 0);
            add(1, 4'hF, 1, 1, 8'hFF, 0);
        end
        add(1, 4'h7, 1, 0, 8'h00, 1);
        add(1, 4'h5, 1, 0, 8'h00, 1);
        add(1, 4'hA, 1, 1, 8'hA5, 1);
        add(1, 4'h0, 1, 0, 8'h00, 1);
        add(0, 4'h0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 6; i++) add(1, 4'hF, 0, 0, 8'h00, 1);
        add(1, 4'h7, 0, 0, 8'h00, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].arm, tbl[i].nib);
            chk($sformatf("row%0d_lock", i), O_locked, tbl[i].exp_lock);
            chk($sformatf("row%0d_valid", i), O_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid)
                chk($sformatf("row%0d_data", i), O_data, tbl[i].exp_data);
            chk($sformatf("row%0d_rs", i), O_resync_count, tbl[i].exp_rs);
        end

        // overflow: fill 16, drop 17th, clear, push on full with pop
        do_reset();
        I_ready = 1'b0;
        lock_seq();
        chk("ovf_locked", O_locked, 1);
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = 8'(i);
            step(1'b1, b[3:0]);
            if (i == 16) I_clear_overflow = 1'b1;
            step(1'b1, b[7:4]);
            I_clear_overflow = 1'b0;
            if (i == 15) chk("ovf_full_no_drop", O_overflow, 0);
        end
        chk("ovf_set_wins", O_overflow, 1);
        chk("ovf_head", O_data, 8'h00);
        chk("ovf_valid", O_valid, 1);
        I_clear_overflow = 1'b1;
        step(1'b1, 4'hB);
        I_clear_overflow = 1'b0;
        chk("ovf_cleared", O_overflow, 0);
        I_ready = 1'b1;
        step(1'b1, 4'hA);
        chk("ovf_fullpop_no_ovf", O_overflow, 0);
        for (int k = 0; k < 16; k++) begin
            logic [7:0] e;
            e = (k < 15) ? 8'(k + 1) : 8'hAB;
            chk($sformatf("drain%0d_valid", k), O_valid, 1);
            chk($sformatf("drain%0d_data", k), O_data, e);
            step(1'b0, 4'h0);
        end
        chk("drain_empty", O_valid, 0);

        // reset mid-byte with three bytes queued
        do_reset();
        I_ready = 1'b0;
        lock_seq();
        step(1'b1, 4'h1); step(1'b1, 4'h2);
        step(1'b1, 4'h3); step(1'b1, 4'h4);
        step(1'b1, 4'h5); step(1'b1, 4'h6);
        step(1'b1, 4'h9);
        chk("pre_rst_head", O_data, 8'h21);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_locked", O_locked, 0);
        chk("async_valid", O_valid, 0);
        chk("async_data", O_data, 0);
        chk("async_ovf", O_overflow, 0);
        chk("async_rs", O_resync_count, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 4'h8); step(1'b1, 4'h9);
        step(1'b1, 4'hA); step(1'b1, 4'hB);
        chk("post_rst_nolock", O_locked, 0);
        chk("post_rst_novalid", O_valid, 0);
        lock_seq();
        step(1'b1, 4'h9); step(1'b1, 4'h8);
        chk("resync_byte", O_data, 8'h89);
        step(1'b1, 4'hA); step(1'b1, 4'hB);

        // disarm with two bytes queued
        step(1'b0, 4'h0);
        chk("disarm_locked", O_locked, 0);
        chk("disarm_valid", O_valid, 1);
        I_ready = 1'b1;
        chk("disarm_d0", O_data, 8'h89);
        step(1'b0, 4'h0);
        chk("disarm_d1", O_data, 8'hBA);
        chk("disarm_v1", O_valid, 1);
        step(1'b0, 4'h0);
        chk("disarm_empty", O_valid, 0);
        chk("disarm_rs", O_resync_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, byte-FIFO entries (power of two, 4..256).
REQ-002 SHALL have ports:
  clk  input  1  sole clock; all sampling on rising edge.
  reset_n  input  1  asynchronous, active-low reset.
  I_arm  input  1  capture enable; low forces HUNT.
  TRACEDATA  input  4  parallel trace nibble, one per clk.
  I_clear_overflow  input  1  pulse clears O_overflow.
  O_data  output  8  head-of-FIFO trace byte.
  O_valid  output  1  O_data valid.
  I_ready  input  1  consumer accepts byte when O_valid and I_ready.
  O_locked  output  1  state == LOCKED.
  O_overflow  output  1  sticky: byte dropped on full FIFO.
  O_resync_count  output  8  misaligned-sync events, saturating.
REQ-003 SHALL use one clock (clk); reset is asynchronous, active-low (reset_n).

Function
REQ-004 SHALL sample TRACEDATA every rising clk edge; no nibble skipped or double-sampled.
REQ-005 SHALL keep a 3-bit ones-run counter: nibble 0xF -> run = min(run+1, 7); any other nibble -> run = 0; counts in every state while I_arm high.
REQ-006 SHALL flag sync when the sampled nibble is 0x7 and run == 7 (frame sync FF FF FF 7F, low nibble first).
REQ-007 SHALL implement states HUNT and LOCKED; HUNT -> LOCKED on sync with I_arm high; any state -> HUNT when I_arm low.
REQ-008 In HUNT, SHALL push nothing into the FIFO.
REQ-009 On HUNT -> LOCKED, SHALL set phase = 0 (next nibble is a low nibble).
REQ-010 In LOCKED, phase 0: SHALL latch nibble as low half, phase <= 1; phase 1: SHALL push byte {nibble, low}, phase <= 0.
REQ-011 Sync in LOCKED with phase 1 (aligned): SHALL push 0x7F normally; O_resync_count unchanged.
REQ-012 Sync in LOCKED with phase 0 (misaligned): SHALL push nothing, keep phase 0, increment O_resync_count (saturate 255).
REQ-013 A byte pushed at edge N SHALL appear with O_valid high after edge N when FIFO was empty (one-cycle latency from high nibble).
REQ-014 FIFO SHALL be first-word-fall-through; pop on O_valid && I_ready at rising edge.
REQ-015 Push when full and no pop: byte dropped, O_overflow <= 1; push when full with simultaneous pop: byte accepted.
REQ-016 O_overflow SHALL stay high until I_clear_overflow; simultaneous set and clear -> set wins.
REQ-017 I_arm low SHALL clear phase and run counter, retain FIFO contents and O_resync_count; draining continues.
REQ-018 O_data SHALL be don't-care when O_valid low; O_valid SHALL never drop without a pop.

Reset
REQ-019 reset_n low SHALL immediately force: state HUNT, phase 0, run 0, FIFO empty, O_valid 0, O_data 0x00, O_locked 0, O_overflow 0, O_resync_count 0.
REQ-020 Reset mid-byte SHALL discard the partial low nibble; first byte after reset requires fresh sync.

Structure
REQ-021 Shared package trace_pkg SHALL hold SYNC_RUN_NIBBLE (4'hF), SYNC_END_NIBBLE (4'h7), SYNC_RUN_LEN (7), and the HUNT/LOCKED state enum.
REQ-022 FIFO SHALL be sub-module trace_byte_fifo (parameter FIFO_DEPTH, width 8, async active-low reset, full/empty, FWFT).

Verification
REQ-023 I_arm=1, nibbles F x7, 7, then 4,3,2,1 -> O_locked rises after the 7; bytes 0x34, 0x12 out in order; O_resync_count 0.
REQ-024 Locked; stream F x6, 7 -> no lock change (run 6), data bytes pass unchanged; in HUNT same stream -> no lock.
REQ-025 Locked at phase 0; nibble C then F x7, 7, then 5,A -> misaligned sync: O_resync_count 1, next byte 0xA5.
REQ-026 FIFO_DEPTH=16, I_ready=0, push 17 bytes -> 16 retained, O_overflow 1; I_clear_overflow pulse -> 0; full push with I_ready=1 -> accepted, no overflow.
REQ-027 Drop reset_n mid-byte while locked with 3 bytes queued -> all outputs zero immediately; after release, bytes only after new sync.
REQ-028 Drop I_arm with 2 bytes queued -> O_locked 0 next edge; both bytes still drain with I_ready=1.
